// File: rtl/gameconsole_pkg.sv
// gameconsole_pkg: shared raster geometry, line buffer widths and raster position type.
package gameconsole_pkg;
    localparam int SCREEN_W        = 320;
    localparam int SCREEN_H        = 240;
    localparam int SCREEN_HBLANK   = 80;
    localparam int SCREEN_VBLANK   = 80;
    localparam int LINEBUFF_BANK_W = 1;
    localparam int LINEBUFF_ADDR_W = 9;
    localparam int LINEBUFF_DATA_W = 32;
    localparam int LINE_TOTAL      = SCREEN_W + SCREEN_HBLANK;
    localparam int FRAME_TOTAL     = SCREEN_H + SCREEN_VBLANK;
    localparam int HCNT_W          = 9;
    localparam int VCNT_W          = 9;

    typedef struct packed {
        logic [HCNT_W-1:0] x;
        logic [VCNT_W-1:0] y;
    } raster_pos_t;
endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen: hcnt/vcnt raster counters advanced by the pixel strobe, with blank decode.
module video_timing_gen
    import gameconsole_pkg::*;
#(
    parameter int H_ACTIVE = SCREEN_W,
    parameter int H_TOTAL  = LINE_TOTAL,
    parameter int V_ACTIVE = SCREEN_H,
    parameter int V_TOTAL  = FRAME_TOTAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pix_en,
    output logic [HCNT_W-1:0] o_hcnt,
    output logic [VCNT_W-1:0] o_vcnt,
    output logic              o_hblank,
    output logic              o_vblank,
    output logic              o_active
);
    logic [HCNT_W-1:0] r_hcnt;
    logic [VCNT_W-1:0] r_vcnt;
    logic              w_hwrap;
    logic              w_vwrap;

    assign w_hwrap  = r_hcnt == HCNT_W'(H_TOTAL - 1);
    assign w_vwrap  = r_vcnt == VCNT_W'(V_TOTAL - 1);
    assign o_hcnt   = r_hcnt;
    assign o_vcnt   = r_vcnt;
    assign o_hblank = r_hcnt >= HCNT_W'(H_ACTIVE);
    assign o_vblank = r_vcnt >= VCNT_W'(V_ACTIVE);
    assign o_active = !o_hblank && !o_vblank;

    // vcnt starts on the last blank line so the first strobe requests line 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt <= '0;
            r_vcnt <= VCNT_W'(V_TOTAL - 1);
        end else if (i_pix_en) begin
            r_hcnt <= w_hwrap ? '0 : r_hcnt + 1'b1;
            if (w_hwrap)
                r_vcnt <= w_vwrap ? '0 : r_vcnt + 1'b1;
        end
    end
endmodule

// File: rtl/linebuff_scanout.sv
// linebuff_scanout: raster scan-out from the two-bank line buffer, one-line-ahead render
// requests, bank ready tracking, underrun detection and a fixed 2-clk output pipeline.
module linebuff_scanout #(
    parameter int SCREEN_W        = gameconsole_pkg::SCREEN_W,
    parameter int SCREEN_H        = gameconsole_pkg::SCREEN_H,
    parameter int SCREEN_HBLANK   = gameconsole_pkg::SCREEN_HBLANK,
    parameter int SCREEN_VBLANK   = gameconsole_pkg::SCREEN_VBLANK,
    parameter int LINEBUFF_BANK_W = gameconsole_pkg::LINEBUFF_BANK_W,
    parameter int LINEBUFF_ADDR_W = gameconsole_pkg::LINEBUFF_ADDR_W,
    parameter int LINEBUFF_DATA_W = gameconsole_pkg::LINEBUFF_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_en,
    output logic                       lb_rd_en,
    output logic [LINEBUFF_BANK_W-1:0] lb_rd_bank,
    output logic [LINEBUFF_ADDR_W-1:0] lb_rd_addr,
    input  logic [LINEBUFF_DATA_W-1:0] lb_rd_data,
    output logic                       line_req,
    output logic [8:0]                 line_req_y,
    output logic [LINEBUFF_BANK_W-1:0] line_req_bank,
    input  logic                       line_done,
    output logic                       pix_valid,
    output logic [LINEBUFF_DATA_W-1:0] pix_data,
    output logic [8:0]                 pix_x,
    output logic [8:0]                 pix_y,
    output logic                       hblank,
    output logic                       vblank,
    output logic                       frame_start,
    output logic                       underrun,
    input  logic                       underrun_clr
);
    import gameconsole_pkg::*;

    localparam int H_TOTAL = SCREEN_W + SCREEN_HBLANK;
    localparam int V_TOTAL = SCREEN_H + SCREEN_VBLANK;
    localparam int NBANK   = 2 ** LINEBUFF_BANK_W;

    logic [HCNT_W-1:0]          w_hcnt;
    logic [VCNT_W-1:0]          w_vcnt;
    logic [VCNT_W-1:0]          w_next_y;
    logic                       w_hblank, w_vblank, w_active;
    logic                       w_stb, w_line_start, w_ls_act, w_req, w_done, w_rd, w_ur_set;
    logic [LINEBUFF_BANK_W-1:0] w_disp_bank, w_next_bank;
    logic [NBANK-1:0]           r_ready, w_ready_nxt;
    logic                       r_outstanding, r_line_ok, r_underrun;
    logic                       r_line_req;
    logic [VCNT_W-1:0]          r_line_req_y;
    logic [LINEBUFF_BANK_W-1:0] r_line_req_bank;
    logic                       r_s1_en, r_s1_valid, r_s1_hblank, r_s1_vblank, r_s1_fs;
    raster_pos_t                r_s1_pos, r_s2_pos;
    logic                       r_pix_valid, r_hblank, r_vblank, r_frame_start;
    logic [LINEBUFF_DATA_W-1:0] r_pix_data;

    video_timing_gen #(
        .H_ACTIVE (SCREEN_W),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (SCREEN_H),
        .V_TOTAL  (V_TOTAL)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .i_pix_en (pix_en),
        .o_hcnt   (w_hcnt),
        .o_vcnt   (w_vcnt),
        .o_hblank (w_hblank),
        .o_vblank (w_vblank),
        .o_active (w_active)
    );

    assign w_stb        = pix_en && !rst;
    assign w_line_start = w_stb && w_hcnt == '0;
    assign w_ls_act     = w_line_start && !w_vblank;
    assign w_next_y     = w_vcnt == VCNT_W'(V_TOTAL - 1) ? '0 : w_vcnt + 1'b1;
    assign w_req        = w_line_start && w_next_y < VCNT_W'(SCREEN_H);
    assign w_disp_bank  = LINEBUFF_BANK_W'(w_vcnt[0]);
    assign w_next_bank  = LINEBUFF_BANK_W'(w_next_y[0]);
    assign w_done       = line_done && r_outstanding;
    assign w_rd         = w_stb && w_active;
    assign w_ur_set     = w_ls_act && !r_ready[w_disp_bank];

    assign lb_rd_en      = w_rd;
    assign lb_rd_bank    = w_rd ? w_disp_bank : '0;
    assign lb_rd_addr    = w_rd ? LINEBUFF_ADDR_W'(w_hcnt) : '0;
    assign line_req      = r_line_req;
    assign line_req_y    = r_line_req_y;
    assign line_req_bank = r_line_req_bank;
    assign underrun      = r_underrun;
    assign pix_valid     = r_pix_valid;
    assign pix_data      = r_pix_data;
    assign pix_x         = r_s2_pos.x;
    assign pix_y         = r_s2_pos.y;
    assign hblank        = r_hblank;
    assign vblank        = r_vblank;
    assign frame_start   = r_frame_start;

    // a done lands on the previous request's bank before a coincident new request clears its own
    always_comb begin
        w_ready_nxt = r_ready;
        if (w_done)
            w_ready_nxt[r_line_req_bank] = 1'b1;
        if (w_req)
            w_ready_nxt[w_next_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready         <= '0;
            r_outstanding   <= 1'b0;
            r_line_ok       <= 1'b0;
            r_underrun      <= 1'b0;
            r_line_req      <= 1'b0;
            r_line_req_y    <= '0;
            r_line_req_bank <= '0;
        end else begin
            r_ready       <= w_ready_nxt;
            r_outstanding <= w_req || (r_outstanding && !w_done);
            r_line_req    <= w_req;
            if (w_req) begin
                r_line_req_y    <= w_next_y;
                r_line_req_bank <= w_next_bank;
            end
            if (w_ls_act)
                r_line_ok <= r_ready[w_disp_bank];
            r_underrun <= w_ur_set || (r_underrun && !underrun_clr);
        end
    end

    // stage 1 waits on the RAM read; stage 2 presents data with the delayed raster fields
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_en       <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_hblank   <= 1'b0;
            r_s1_vblank   <= 1'b0;
            r_s1_fs       <= 1'b0;
            r_s1_pos      <= '0;
            r_s2_pos      <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_data    <= '0;
            r_hblank      <= 1'b0;
            r_vblank      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_s1_en     <= pix_en;
            r_s1_valid  <= w_rd;
            r_s1_hblank <= pix_en && w_hblank;
            r_s1_vblank <= pix_en && w_vblank;
            r_s1_fs     <= pix_en && w_hcnt == '0 && w_vcnt == '0;
            if (pix_en)
                r_s1_pos <= '{x: w_hcnt, y: w_vcnt};
            if (r_s1_en)
                r_s2_pos <= r_s1_pos;
            r_pix_valid   <= r_s1_valid;
            r_pix_data    <= r_s1_valid && r_line_ok ? lb_rd_data : '0;
            r_hblank      <= r_s1_hblank;
            r_vblank      <= r_s1_vblank;
            r_frame_start <= r_s1_fs;
        end
    end
endmodule
